// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and iterative one-bit-per-cycle shifts.
// The result register doubles as a one-entry output buffer under backpressure.
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_INC  = 3'b001;
   localparam logic [2:0] OP_NEG  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_PASS = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;

   logic [0:0]         state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               out_valid_d, zero_d, neg_d, carry_d, overflow_d;
   logic [WIDTH-1:0]   result_d;

   logic               accept;
   logic               is_shift;
   logic [SHAMT_W-1:0] k;
   logic [WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum, diff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   assign in_ready = !reset && (state_q == IDLE) && (!out_valid || out_ready);
   assign busy     = (state_q == SHIFT);
   assign accept   = in_valid && in_ready;
   assign is_shift = (opcode[2:1] == 2'b11);
   assign k        = b[SHAMT_W-1:0];
   // dir_q set selects a logical right shift
   assign shifted  = dir_q ? (acc_q >> 1) : (acc_q << 1);

   // Single-cycle datapath; shifts only reach here with k == 0
   always_comb begin
      alu_res = a;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      addend  = (opcode == OP_INC) ? WIDTH'(1) : a;
      sum     = {1'b0, b} + {1'b0, addend};
      diff    = {1'b0, b} - {1'b0, a};
      case (opcode)
         OP_ADD, OP_INC: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (b[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != b[WIDTH-1]);
         end
         OP_NEG: begin
            alu_res = {WIDTH{1'b0}} - a;
            alu_v   = (a == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = !diff[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
         end
         OP_PASS: alu_res = a;
         OP_AND:  alu_res = a & b;
         default: alu_res = a;
      endcase
   end

   // Next-state and output-register logic
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      out_valid_d = out_valid;
      result_d    = result;
      zero_d      = zero;
      neg_d       = neg;
      carry_d     = carry;
      overflow_d  = overflow;

      if (out_valid && out_ready) out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_shift && (k != '0)) begin
                  acc_d   = a;
                  cnt_d   = k;
                  dir_d   = opcode[0];
                  state_d = SHIFT;
               end else begin
                  result_d    = alu_res;
                  zero_d      = (alu_res == '0);
                  neg_d       = alu_res[WIDTH-1];
                  carry_d     = alu_c;
                  overflow_d  = alu_v;
                  out_valid_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            acc_d = shifted;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d    = shifted;
               zero_d      = (shifted == '0);
               neg_d       = shifted[WIDTH-1];
               carry_d     = 1'b0;
               overflow_d  = 1'b0;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         out_valid <= out_valid_d;
         result    <= result_d;
         zero      <= zero_d;
         neg       <= neg_d;
         carry     <= carry_d;
         overflow  <= overflow_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against an
// arithmetic reference model; a second 8-bit instance covers the narrow build.
module tb_alu_seq;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  opcode;
   logic [31:0] a, b, result;
   logic        zero, neg, carry, overflow, busy;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [2:0]  opcode8;
   logic [7:0]  a8, b8, result8;
   logic        zero8, neg8, carry8, overflow8, busy8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .neg(neg), .carry(carry), .overflow(overflow),
      .busy(busy)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .opcode(opcode8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .zero(zero8), .neg(neg8), .carry(carry8), .overflow(overflow8),
      .busy(busy8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model from the opcode definitions using wide signed/unsigned arithmetic
   function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic c, output logic v);
      longint us, s;
      int     k;
      k = int'(y % 32);
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0, 3'd1: begin
            if (op == 3'd1) x = 32'd1;
            us = longint'(x) + longint'(y);
            s  = longint'($signed(x)) + longint'($signed(y));
            r  = 32'(us);
            c  = (us > 64'sd4294967295);
            v  = (s > SMAX) || (s < SMIN);
         end
         3'd2: begin
            s = -longint'($signed(x));
            r = 32'(s);
            v = (s > SMAX);
         end
         3'd3: begin
            s = longint'($signed(y)) - longint'($signed(x));
            r = 32'(s);
            c = (y >= x);
            v = (s > SMAX) || (s < SMIN);
         end
         3'd4: r = x;
         3'd5: r = x & y;
         3'd6: r = x << k;
         default: r = x >> k;
      endcase
   endfunction

   // One op with out_ready held high; checks latency, busy window and all outputs
   task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
      logic [31:0] er;
      logic        ec, ev;
      int          k, waits, busy_cnt, exp_waits;
      model(op, x, y, er, ec, ev);
      k         = int'(y[4:0]);
      exp_waits = (op[2:1] == 2'b11 && k != 0) ? k : 0;
      @(negedge clk);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; opcode = op; a = x; b = y;
      @(negedge clk);
      in_valid = 1'b0; opcode = 3'($urandom); a = $urandom; b = $urandom;
      waits = 0; busy_cnt = 0;
      while (!out_valid && waits < 64) begin
         in_valid = busy;
         if (busy) begin
            busy_cnt++;
            check({tag, "_ready_in_shift"}, 64'(in_ready), 64'd0);
         end
         @(negedge clk);
         waits++;
      end
      in_valid = 1'b0;
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_latency"},   64'(waits), 64'(exp_waits));
      check({tag, "_busy_cyc"},  64'(busy_cnt), 64'(exp_waits));
      check({tag, "_result"},    64'(result), 64'(er));
      check({tag, "_zero"},      64'(zero), 64'(er == 32'd0));
      check({tag, "_neg"},       64'(neg), 64'(er[31]));
      check({tag, "_carry"},     64'(carry), 64'(ec));
      check({tag, "_overflow"},  64'(overflow), 64'(ev));
   endtask

   initial begin
      logic [31:0] vals [4];
      logic [31:0] x, y, held;
      logic [2:0]  op;
      logic        seen;
      int          waits;

      reset = 1'b1;
      in_valid = 1'b0; opcode = '0; a = '0; b = '0; out_ready = 1'b1;
      in_valid8 = 1'b0; opcode8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result",    64'(result), 64'd0);
      check("rst_in_ready",  64'(in_ready), 64'd0);
      check("rst_busy",      64'(busy), 64'd0);
      reset = 1'b0;

      run_op(3'd0, 32'hFFFF_FFFF, 32'd1, "add_wrap");
      run_op(3'd3, 32'd5, 32'd3, "sub_neg");
      run_op(3'd2, 32'h8000_0000, 32'h0, "neg_min");
      run_op(3'd6, 32'h1, 32'd31, "shl_31");
      run_op(3'd7, 32'h8000_0000, 32'd0, "shr_0");
      run_op(3'd7, 32'hF000_000F, 32'h0000_0124, "shr_4");
      run_op(3'd3, 32'h8000_0000, 32'h0000_0001, "sub_ovf");
      run_op(3'd5, 32'hF0F0_F0F0, 32'h0F0F_0F0F, "and_zero");

      // Four INC ops on consecutive cycles must stream out one per cycle
      for (int i = 0; i < 4; i++) vals[i] = $urandom;
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) begin
            check("b2b_valid",  64'(out_valid), 64'd1);
            check("b2b_result", 64'(result), 64'(vals[i-1] + 32'd1));
         end
         if (i < 4) begin
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1; opcode = 3'd1; a = $urandom; b = vals[i];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end

      // Backpressure: result holds and nothing new is accepted
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = 3'd4; a = 32'hCAFE_0001; b = $urandom;
      @(negedge clk);
      held = 32'hCAFE_0001;
      opcode = 3'd0; a = 32'h1111_1111; b = 32'h2222_2222;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid",    64'(out_valid), 64'd1);
         check("bp_result",   64'(result), 64'(held));
         check("bp_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_drained", 64'(out_valid), 64'd0);

      // Asynchronous reset mid-shift aborts the op
      in_valid = 1'b1; opcode = 3'd7; a = 32'hF0F0_0000; b = 32'd10;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_result",    64'(result), 64'd0);
      check("arst_flags",     64'({zero, neg, carry, overflow}), 64'd0);
      check("arst_busy",      64'(busy), 64'd0);
      check("arst_in_ready",  64'(in_ready), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("arst_no_result", 64'(seen), 64'd0);
      check("arst_ready_after", 64'(in_ready), 64'd1);
      run_op(3'd4, 32'h0000_1234, $urandom, "pass_after_rst");

      // Random ops against the model
      for (int n = 0; n < 150; n++) begin
         op = 3'($urandom_range(0, 7));
         x  = $urandom;
         y  = $urandom;
         case ($urandom_range(0, 7))
            0: x = 32'h8000_0000;
            1: x = 32'hFFFF_FFFF;
            2: y = 32'h7FFF_FFFF;
            3: y = x;
            default: ;
         endcase
         run_op(op, x, y, "rand");
      end

      // Narrow build
      @(negedge clk);
      in_valid8 = 1'b1; opcode8 = 3'd0; a8 = 8'h7F; b8 = 8'h01;
      @(negedge clk);
      in_valid8 = 1'b0;
      check("w8_add_valid", 64'(out_valid8), 64'd1);
      check("w8_add_result", 64'(result8), 64'h80);
      check("w8_add_flags", 64'({zero8, neg8, carry8, overflow8}), 64'b0101);
      in_valid8 = 1'b1; opcode8 = 3'd6; a8 = 8'h03; b8 = 8'hFA;
      @(negedge clk);
      in_valid8 = 1'b0;
      waits = 0;
      while (!out_valid8 && waits < 16) begin
         @(negedge clk);
         waits++;
      end
      check("w8_shl_latency", 64'(waits), 64'd2);
      check("w8_shl_result", 64'(result8), 64'h0C);
      check("w8_shl_flags", 64'({zero8, neg8, carry8, overflow8}), 64'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the datapath ALU used in the CPU execute stage. It accepts one operation per valid/ready handshake and returns a registered result with zero, neg, carry and overflow flags. All eight 3-bit opcodes are defined. Two new iterative shift operations take multiple cycles, one bit position per cycle, so the block contains a small FSM and output buffering under backpressure.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two, minimum 4.
SHAMT_W, $clog2(WIDTH), derived localparam, not overridable; shift-amount field width taken from b[SHAMT_W-1:0].

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation this cycle
opcode  input  3  operation select (see Behaviour)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  registered result
zero  output  1  result == 0
neg  output  1  result[WIDTH-1]
carry  output  1  unsigned carry-out / no-borrow
overflow  output  1  signed overflow
busy  output  1  FSM in SHIFT state

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE; out_valid, result, zero, neg, carry, overflow = 0; shift counter = 0.
  - in_ready is 0 while reset is asserted.
- in_ready = !reset && state==IDLE && (!out_valid || out_ready). The operation is accepted on the edge where in_valid && in_ready.
- Opcodes, width-WIDTH modular arithmetic:
  - 000 ADD: b+a
  - 001 INC: b+1
  - 010 NEG: 0-a
  - 011 SUB: b-a
  - 100 PASS: a
  - 101 AND: a&b
  - 110 SHL: a<<k
  - 111 SHR (logical): a>>k
  - For shifts, k = b[SHAMT_W-1:0].
- carry:
  - ADD/INC: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: 1 when b>=a unsigned (no borrow).
  - All other opcodes: 0.
- overflow:
  - ADD/INC: operands share a sign and the result sign differs.
  - SUB: a and b differ in sign and the result sign != b sign.
  - NEG: 1 only when a == 100..0.
  - All other opcodes: 0.
- zero and neg are computed from the final result for every opcode.
- Single-cycle ops (000-101, and SHL/SHR with k==0): result and flags are registered on the accept edge; out_valid=1 after that edge. Latency is 1.
- Shift FSM, states IDLE and SHIFT:
  - Accept with k>=1: acc=a, cnt=k, direction latched, go to SHIFT, busy=1.
  - Each SHIFT edge: acc shifts one bit (zero fill); cnt decrements.
  - On the edge where cnt goes 1->0: result=shifted acc, flags registered, out_valid=1, state=IDLE.
  - Latency is k cycles.
- in_ready=0 throughout SHIFT; in_valid is ignored there.
- Output buffer:
  - While out_valid && !out_ready, result and flags hold stable and no new op is accepted.
  - out_valid clears on out_ready unless a new single-cycle op is accepted in the same cycle. In that case out_valid stays 1 with the new data, giving full throughput of 1 op/cycle.
- Shift completion cannot collide with a pending output, because SHIFT is entered only when the output register is empty or draining.
- Reset asserted mid-SHIFT aborts the operation; no result is produced.
- Operand changes after accept have no effect; all inputs are sampled at accept.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> 1 cycle later out_valid=1, result=0, zero=1, carry=1, overflow=0, neg=0.
- SUB a=5, b=3 -> result=0xFFFFFFFE, neg=1, carry=0, overflow=0; NEG a=0x80000000 -> result=0x80000000, overflow=1.
- SHL a=0x1, b=31 -> busy for 31 cycles, in_ready=0, then result=0x80000000, neg=1; SHR a=0x80000000, b=0 -> 1-cycle latency, result unchanged.
- Back-to-back: INC ops on 4 consecutive cycles with out_ready=1 -> results on 4 consecutive cycles; then out_ready=0 for 3 cycles -> result stable and in_ready=0 until out_ready returns.
- Reset asserted asynchronously mid-clock during SHR k=10 at cycle 4 -> all outputs 0 immediately, out_valid never asserts; after release, in_ready=1 and a PASS a=0x1234 returns 0x1234.
- WIDTH=8 build: ADD a=0x7F, b=0x01 -> result=0x80, overflow=1, neg=1, carry=0; SHL a=0x03, b=0xFA (k=2) -> result=0x0C after 2 cycles.
